// File: rtl/mano_pkg.sv
// rtl/mano_pkg.sv - Shared types, bus/ALU encodings and IR bit masks for the Mano control unit
package mano_pkg;

  localparam int ADDR_W = 12;

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6} sc_t;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_AR   = 3'd1,
    BUS_PC   = 3'd2,
    BUS_DR   = 3'd3,
    BUS_AC   = 3'd4,
    BUS_IR   = 3'd5,
    BUS_TR   = 3'd6,
    BUS_MEM  = 3'd7
  } bus_sel_t;

  typedef enum logic [2:0] {
    ALU_PASS_DR = 3'd0,
    ALU_AND     = 3'd1,
    ALU_ADD     = 3'd2,
    ALU_CMA     = 3'd3,
    ALU_SHR     = 3'd4,
    ALU_SHL     = 3'd5
  } alu_op_t;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_ADD = 3'd1,
    OP_LDA = 3'd2,
    OP_STA = 3'd3,
    OP_BUN = 3'd4,
    OP_BSA = 3'd5,
    OP_ISZ = 3'd6,
    OP_REG = 3'd7
  } opcode_t;

  // Register-reference and I/O operations are one-hot in IR[11:0]
  localparam logic [11:0] RR_CLA = 12'h800;
  localparam logic [11:0] RR_CLE = 12'h400;
  localparam logic [11:0] RR_CMA = 12'h200;
  localparam logic [11:0] RR_CME = 12'h100;
  localparam logic [11:0] RR_CIR = 12'h080;
  localparam logic [11:0] RR_CIL = 12'h040;
  localparam logic [11:0] RR_INC = 12'h020;
  localparam logic [11:0] RR_SPA = 12'h010;
  localparam logic [11:0] RR_SNA = 12'h008;
  localparam logic [11:0] RR_SZA = 12'h004;
  localparam logic [11:0] RR_SZE = 12'h002;
  localparam logic [11:0] RR_HLT = 12'h001;
  localparam logic [11:0] IO_ION = 12'h080;
  localparam logic [11:0] IO_IOF = 12'h040;

  typedef struct packed {
    logic     ar_ld;
    logic     ar_inc;
    logic     ar_clr;
    logic     pc_ld;
    logic     pc_inc;
    logic     pc_clr;
    logic     dr_ld;
    logic     dr_inc;
    logic     ac_ld;
    logic     ac_inc;
    logic     ac_clr;
    logic     ir_ld;
    logic     tr_ld;
    bus_sel_t bus_sel;
    logic     mem_rd;
    logic     mem_wr;
    alu_op_t  alu_op;
    logic     e_ld;
    logic     e_clr;
    logic     e_cmp;
  } ctrl_t;

endpackage

// File: rtl/mano_seq_counter.sv
// rtl/mano_seq_counter.sv - Sequence counter T0..T6 with inc/clr and one-hot timing decode
module mano_seq_counter
  import mano_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inc,
  input  logic       clr,
  output logic [6:0] t
);

  sc_t sc;
  sc_t sc_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sc <= T0;
    else          sc <= sc_next;
  end

  // Wrapping out of T6 keeps SC inside the legal range even if inc is left high
  always_comb begin
    sc_next = sc;
    if (clr)      sc_next = T0;
    else if (inc) sc_next = (sc == T6) ? T0 : sc_t'(3'(sc + 3'd1));
  end

  assign t = 7'b1 << sc;

endmodule

// File: rtl/mano_control_unit.sv
// rtl/mano_control_unit.sv - Hardwired Mano basic-computer control unit
// Define MANO_INTERRUPT_EN to add intr_req, IEN/R flip-flops and the interrupt cycle.
module mano_control_unit
  import mano_pkg::*;
#(
  parameter int ADDR_W = mano_pkg::ADDR_W
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
`ifdef MANO_INTERRUPT_EN
  input  logic        intr_req,
`endif
  input  logic [15:0] ir,
  input  logic        ac_msb,
  input  logic        ac_zero,
  input  logic        dr_zero,
  input  logic        e_in,
  output logic        ar_ld,
  output logic        ar_inc,
  output logic        ar_clr,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        pc_clr,
  output logic        dr_ld,
  output logic        dr_inc,
  output logic        ac_ld,
  output logic        ac_inc,
  output logic        ac_clr,
  output logic        ir_ld,
  output logic        tr_ld,
  output logic [2:0]  bus_sel,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [2:0]  alu_op,
  output logic        e_ld,
  output logic        e_clr,
  output logic        e_cmp,
  output logic        halted
);

  logic [6:0] t;
  logic       sc_inc, sc_clr;
  logic       load_di, halt_set;
  opcode_t    d;
  logic       i_bit;
  logic       s_run;
  ctrl_t      c, o;

`ifdef MANO_INTERRUPT_EN
  logic ien, r_flag;
  logic ien_set, ien_clr, r_set, r_clr;
`endif

  mano_seq_counter u_sc (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (sc_inc),
    .clr     (sc_clr),
    .t       (t)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d     <= OP_AND;
      i_bit <= 1'b0;
      s_run <= 1'b1;
`ifdef MANO_INTERRUPT_EN
      ien    <= 1'b0;
      r_flag <= 1'b0;
`endif
    end else begin
      if (load_di) begin
        d     <= opcode_t'(ir[14:12]);
        i_bit <= ir[15];
      end
      if (halt_set)            s_run <= 1'b0;
      else if (start && !s_run) s_run <= 1'b1;
`ifdef MANO_INTERRUPT_EN
      if (ien_set)      ien <= 1'b1;
      else if (ien_clr) ien <= 1'b0;
      if (r_set)        r_flag <= 1'b1;
      else if (r_clr)   r_flag <= 1'b0;
`endif
    end
  end

  always_comb begin
    c        = '0;
    sc_inc   = 1'b0;
    sc_clr   = 1'b0;
    load_di  = 1'b0;
    halt_set = 1'b0;
`ifdef MANO_INTERRUPT_EN
    ien_set  = 1'b0;
    ien_clr  = 1'b0;
    r_set    = 1'b0;
    r_clr    = 1'b0;
`endif
    if (!s_run) begin
      sc_clr = 1'b1;
    end
`ifdef MANO_INTERRUPT_EN
    else if (r_flag) begin
      // Save return address at M[0] and vector to address 1
      case (1'b1)
        t[0]: begin c.ar_clr = 1'b1; c.bus_sel = BUS_PC; c.tr_ld = 1'b1; sc_inc = 1'b1; end
        t[1]: begin c.bus_sel = BUS_TR; c.mem_wr = 1'b1; c.pc_clr = 1'b1; sc_inc = 1'b1; end
        t[2]: begin c.pc_inc = 1'b1; ien_clr = 1'b1; r_clr = 1'b1; sc_clr = 1'b1; end
        default: begin r_clr = 1'b1; sc_clr = 1'b1; end
      endcase
    end
`endif
    else begin
      case (1'b1)
        t[0]: begin c.bus_sel = BUS_PC; c.ar_ld = 1'b1; sc_inc = 1'b1; end
        t[1]: begin
          c.mem_rd = 1'b1; c.bus_sel = BUS_MEM; c.ir_ld = 1'b1; c.pc_inc = 1'b1; sc_inc = 1'b1;
        end
        t[2]: begin load_di = 1'b1; c.bus_sel = BUS_IR; c.ar_ld = 1'b1; sc_inc = 1'b1; end
        t[3]: begin
          if (d != OP_REG) begin
            if (i_bit) begin c.mem_rd = 1'b1; c.bus_sel = BUS_MEM; c.ar_ld = 1'b1; end
            sc_inc = 1'b1;
          end else begin
            sc_clr = 1'b1;
            // Exact-match decode: anything not one-hot falls to the NOP default
            if (!i_bit)
              case (ir[ADDR_W-1:0])
                RR_CLA: c.ac_clr = 1'b1;
                RR_CLE: c.e_clr  = 1'b1;
                RR_CMA: begin c.alu_op = ALU_CMA; c.ac_ld = 1'b1; end
                RR_CME: c.e_cmp  = 1'b1;
                RR_CIR: begin c.alu_op = ALU_SHR; c.ac_ld = 1'b1; c.e_ld = 1'b1; end
                RR_CIL: begin c.alu_op = ALU_SHL; c.ac_ld = 1'b1; c.e_ld = 1'b1; end
                RR_INC: c.ac_inc = 1'b1;
                RR_SPA: c.pc_inc = !ac_msb;
                RR_SNA: c.pc_inc = ac_msb;
                RR_SZA: c.pc_inc = ac_zero;
                RR_SZE: c.pc_inc = !e_in;
                RR_HLT: halt_set = 1'b1;
                default: ;
              endcase
`ifdef MANO_INTERRUPT_EN
            else
              case (ir[ADDR_W-1:0])
                IO_ION: ien_set = 1'b1;
                IO_IOF: ien_clr = 1'b1;
                default: ;
              endcase
            r_set = ien && intr_req;
`endif
          end
        end
        t[4]: begin
          case (d)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
              c.mem_rd = 1'b1; c.bus_sel = BUS_MEM; c.dr_ld = 1'b1; sc_inc = 1'b1;
            end
            OP_STA: begin c.bus_sel = BUS_AC; c.mem_wr = 1'b1; sc_clr = 1'b1; end
            OP_BUN: begin c.bus_sel = BUS_AR; c.pc_ld = 1'b1; sc_clr = 1'b1; end
            OP_BSA: begin c.bus_sel = BUS_PC; c.mem_wr = 1'b1; c.ar_inc = 1'b1; sc_inc = 1'b1; end
            default: sc_clr = 1'b1;
          endcase
        end
        t[5]: begin
          sc_clr = 1'b1;
          case (d)
            OP_AND: begin c.alu_op = ALU_AND; c.ac_ld = 1'b1; end
            OP_ADD: begin c.alu_op = ALU_ADD; c.ac_ld = 1'b1; c.e_ld = 1'b1; end
            OP_LDA: begin c.alu_op = ALU_PASS_DR; c.ac_ld = 1'b1; end
            OP_BSA: begin c.bus_sel = BUS_AR; c.pc_ld = 1'b1; end
            OP_ISZ: begin c.dr_inc = 1'b1; sc_clr = 1'b0; sc_inc = 1'b1; end
            default: ;
          endcase
        end
        t[6]: begin
          sc_clr = 1'b1;
          if (d == OP_ISZ) begin
            c.bus_sel = BUS_DR; c.mem_wr = 1'b1; c.pc_inc = dr_zero;
          end
        end
        default: sc_clr = 1'b1;
      endcase
    end
  end

  // Strobes must drop the instant reset asserts, not at the next edge
  assign o = reset_n ? c : '0;

  assign ar_ld   = o.ar_ld;
  assign ar_inc  = o.ar_inc;
  assign ar_clr  = o.ar_clr;
  assign pc_ld   = o.pc_ld;
  assign pc_inc  = o.pc_inc;
  assign pc_clr  = o.pc_clr;
  assign dr_ld   = o.dr_ld;
  assign dr_inc  = o.dr_inc;
  assign ac_ld   = o.ac_ld;
  assign ac_inc  = o.ac_inc;
  assign ac_clr  = o.ac_clr;
  assign ir_ld   = o.ir_ld;
  assign tr_ld   = o.tr_ld;
  assign bus_sel = o.bus_sel;
  assign mem_rd  = o.mem_rd;
  assign mem_wr  = o.mem_wr;
  assign alu_op  = o.alu_op;
  assign e_ld    = o.e_ld;
  assign e_clr   = o.e_clr;
  assign e_cmp   = o.e_cmp;
  assign halted  = !s_run;

endmodule

// File: tb/tb_mano_control_unit.sv
// tb/tb_mano_control_unit.sv - Self-checking bench: control unit driving a behavioural Mano datapath
module tb_mano_control_unit;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] m_op;
    logic [15:0] ac0;
    logic        e0;
    logic [15:0] exp_ac;
    logic        exp_e;
    logic [11:0] exp_pc;
    logic [15:0] exp_mem;
    int          exp_cyc;
  } vec_t;

  localparam logic [23:0] T0_WORD = {13'h1000, 3'd2, 2'b00, 3'd0, 3'b000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, start, preload;
`ifdef MANO_INTERRUPT_EN
  logic intr_req = 1'b0;
`endif
  logic ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr, dr_ld, dr_inc;
  logic ac_ld, ac_inc, ac_clr, ir_ld, tr_ld, mem_rd, mem_wr, e_ld, e_clr, e_cmp, halted;
  logic [2:0] bus_sel, alu_op;
  logic [23:0] word;

  logic [11:0] ar, pc;
  logic [15:0] dr, ac, m_ir, tr, bus, alu_res;
  logic        e, alu_e;
  logic [15:0] mem [256];
  logic [15:0] img [256];
  logic [15:0] pre_ac;
  logic        pre_e;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  mano_control_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
`ifdef MANO_INTERRUPT_EN
    .intr_req(intr_req),
`endif
    .ir      (m_ir),
    .ac_msb  (ac[15]),
    .ac_zero (ac == 16'h0000),
    .dr_zero (dr == 16'h0000),
    .e_in    (e),
    .ar_ld   (ar_ld),
    .ar_inc  (ar_inc),
    .ar_clr  (ar_clr),
    .pc_ld   (pc_ld),
    .pc_inc  (pc_inc),
    .pc_clr  (pc_clr),
    .dr_ld   (dr_ld),
    .dr_inc  (dr_inc),
    .ac_ld   (ac_ld),
    .ac_inc  (ac_inc),
    .ac_clr  (ac_clr),
    .ir_ld   (ir_ld),
    .tr_ld   (tr_ld),
    .bus_sel (bus_sel),
    .mem_rd  (mem_rd),
    .mem_wr  (mem_wr),
    .alu_op  (alu_op),
    .e_ld    (e_ld),
    .e_clr   (e_clr),
    .e_cmp   (e_cmp),
    .halted  (halted)
  );

  assign word = {ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr, dr_ld, dr_inc, ac_ld, ac_inc,
                 ac_clr, ir_ld, tr_ld, bus_sel, mem_rd, mem_wr, alu_op, e_ld, e_clr, e_cmp};

  // Behavioural register file, ALU and memory steered by the DUT strobes
  always_comb begin
    case (bus_sel)
      3'd1:    bus = {4'h0, ar};
      3'd2:    bus = {4'h0, pc};
      3'd3:    bus = dr;
      3'd4:    bus = ac;
      3'd5:    bus = m_ir;
      3'd6:    bus = tr;
      3'd7:    bus = mem[ar[7:0]];
      default: bus = 16'h0000;
    endcase
  end

  always_comb begin
    alu_e = e;
    case (alu_op)
      3'd0:    alu_res = dr;
      3'd1:    alu_res = ac & dr;
      3'd2:    {alu_e, alu_res} = {1'b0, ac} + {1'b0, dr};
      3'd3:    alu_res = ~ac;
      3'd4:    begin alu_res = {e, ac[15:1]}; alu_e = ac[0]; end
      3'd5:    begin alu_res = {ac[14:0], e}; alu_e = ac[15]; end
      default: alu_res = ac;
    endcase
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      if (preload) begin
        for (int k = 0; k < 256; k++) mem[k] <= img[k];
        ar <= 12'h000; pc <= 12'h010; dr <= 16'h0000; ac <= pre_ac; e <= pre_e;
        m_ir <= 16'h0000; tr <= 16'h0000;
      end
    end else begin
      if (mem_wr) mem[ar[7:0]] <= bus;
      if (ar_clr) ar <= 12'h000; else if (ar_ld) ar <= bus[11:0]; else if (ar_inc) ar <= ar + 12'd1;
      if (pc_clr) pc <= 12'h000; else if (pc_ld) pc <= bus[11:0]; else if (pc_inc) pc <= pc + 12'd1;
      if (dr_ld) dr <= bus; else if (dr_inc) dr <= dr + 16'd1;
      if (ac_clr) ac <= 16'h0000; else if (ac_ld) ac <= alu_res; else if (ac_inc) ac <= ac + 16'd1;
      if (e_clr) e <= 1'b0; else if (e_cmp) e <= ~e; else if (e_ld) e <= alu_e;
      if (ir_ld) m_ir <= bus;
      if (tr_ld) tr <= bus;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] instr, m_op, ac0, input logic e0,
                     input logic [15:0] exp_ac, input logic exp_e, input logic [11:0] exp_pc,
                     input logic [15:0] exp_mem, input int exp_cyc);
    vec_t v;
    v.instr = instr; v.m_op = m_op; v.ac0 = ac0; v.e0 = e0; v.exp_ac = exp_ac;
    v.exp_e = exp_e; v.exp_pc = exp_pc; v.exp_mem = exp_mem; v.exp_cyc = exp_cyc;
    vecs.push_back(v);
  endtask

  // Instruction at 0x010, address field 0x020; indirect pointer M[0x020]=0x030
  task automatic prep(input logic [15:0] instr, m_op, ac0, input logic e0);
    reset_n = 1'b0;
    preload = 1'b1;
    for (int k = 0; k < 256; k++) img[k] = 16'h0000;
    img[16] = instr;
    if (instr[15]) begin img[32] = 16'h0030; img[48] = m_op; end
    else img[32] = m_op;
    pre_ac = ac0;
    pre_e  = e0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    preload = 1'b0;
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    bit found;
    prep(v.instr, v.m_op, v.ac0, v.e0);
    chk($sformatf("v%0d t0_word", idx), 32'(word), 32'(T0_WORD));
    cyc = 1;
    found = 1'b0;
    while (!found && cyc < 12) begin
      @(negedge clk);
      if (ar_ld && bus_sel == 3'd2) found = 1'b1;
      else cyc++;
    end
    chk($sformatf("v%0d cycles", idx), 32'(cyc), 32'(v.exp_cyc));
    chk($sformatf("v%0d ac", idx), 32'(ac), 32'(v.exp_ac));
    chk($sformatf("v%0d e", idx), 32'(e), 32'(v.exp_e));
    chk($sformatf("v%0d pc", idx), 32'(pc), 32'(v.exp_pc));
    chk($sformatf("v%0d mem", idx), 32'(mem[v.instr[15] ? 48 : 32]), 32'(v.exp_mem));
  endtask

  initial begin
    int bad;
    reset_n = 1'b0;
    start   = 1'b0;
    preload = 1'b0;
    pre_ac  = 16'h0000;
    pre_e   = 1'b0;
    #13;
    chk("reset strobes", 32'(word), 32'h0);
    chk("reset halted", 32'(halted), 32'h0);

    //   instr     m_op      ac0       e0  exp_ac    e   pc       mem       cyc
    add(16'h0020, 16'h0F0F, 16'h3355, 0, 16'h0305, 0, 12'h011, 16'h0F0F, 6);
    add(16'h1020, 16'h0001, 16'hFFFF, 0, 16'h0000, 1, 12'h011, 16'h0001, 6);
    add(16'h9020, 16'h1111, 16'h2222, 1, 16'h3333, 0, 12'h011, 16'h1111, 6);
    add(16'h2020, 16'h1234, 16'h0000, 0, 16'h1234, 0, 12'h011, 16'h1234, 6);
    add(16'hA020, 16'hBEEF, 16'h0001, 1, 16'hBEEF, 1, 12'h011, 16'hBEEF, 6);
    add(16'h3020, 16'h0000, 16'h5A5A, 0, 16'h5A5A, 0, 12'h011, 16'h5A5A, 5);
    add(16'hB020, 16'h0000, 16'hA5A5, 0, 16'hA5A5, 0, 12'h011, 16'hA5A5, 5);
    add(16'h4020, 16'h0007, 16'h0042, 0, 16'h0042, 0, 12'h020, 16'h0007, 5);
    add(16'hC020, 16'h0007, 16'h0042, 0, 16'h0042, 0, 12'h030, 16'h0007, 5);
    add(16'h5020, 16'h0000, 16'h0042, 0, 16'h0042, 0, 12'h021, 16'h0011, 6);
    add(16'hD020, 16'h0000, 16'h0042, 0, 16'h0042, 0, 12'h031, 16'h0011, 6);
    add(16'h6020, 16'hFFFF, 16'h0042, 0, 16'h0042, 0, 12'h012, 16'h0000, 7);
    add(16'h6020, 16'h0005, 16'h0042, 0, 16'h0042, 0, 12'h011, 16'h0006, 7);
    add(16'hE020, 16'h7FFF, 16'h0042, 0, 16'h0042, 0, 12'h011, 16'h8000, 7);
    add(16'h7800, 16'h0000, 16'h1234, 1, 16'h0000, 1, 12'h011, 16'h0000, 4);
    add(16'h7400, 16'h0000, 16'h1234, 1, 16'h1234, 0, 12'h011, 16'h0000, 4);
    add(16'h7200, 16'h0000, 16'h00FF, 0, 16'hFF00, 0, 12'h011, 16'h0000, 4);
    add(16'h7100, 16'h0000, 16'h0001, 0, 16'h0001, 1, 12'h011, 16'h0000, 4);
    add(16'h7080, 16'h0000, 16'h0003, 1, 16'h8001, 1, 12'h011, 16'h0000, 4);
    add(16'h7040, 16'h0000, 16'h8002, 0, 16'h0004, 1, 12'h011, 16'h0000, 4);
    add(16'h7020, 16'h0000, 16'hFFFF, 0, 16'h0000, 0, 12'h011, 16'h0000, 4);
    add(16'h7010, 16'h0000, 16'h0001, 0, 16'h0001, 0, 12'h012, 16'h0000, 4);
    add(16'h7010, 16'h0000, 16'h8000, 0, 16'h8000, 0, 12'h011, 16'h0000, 4);
    add(16'h7008, 16'h0000, 16'h8000, 0, 16'h8000, 0, 12'h012, 16'h0000, 4);
    add(16'h7004, 16'h0000, 16'h0000, 0, 16'h0000, 0, 12'h012, 16'h0000, 4);
    add(16'h7004, 16'h0000, 16'h0001, 0, 16'h0001, 0, 12'h011, 16'h0000, 4);
    add(16'h7002, 16'h0000, 16'h0042, 0, 16'h0042, 0, 12'h012, 16'h0000, 4);
    add(16'h7002, 16'h0000, 16'h0042, 1, 16'h0042, 1, 12'h011, 16'h0000, 4);
    add(16'h7003, 16'h0000, 16'h0042, 0, 16'h0042, 0, 12'h011, 16'h0000, 4);
    add(16'hF080, 16'h0000, 16'h0042, 0, 16'h0042, 0, 12'h011, 16'h0000, 4);

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // HLT: four cycles, then parked with every strobe low until start
    prep(16'h7001, 16'h0000, 16'h0042, 1'b0);
    repeat (3) @(negedge clk);
    chk("hlt running at T3", 32'(halted), 32'h0);
    @(negedge clk);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (!halted || word != 24'h0) bad++;
      @(negedge clk);
    end
    chk("hlt parked cycles bad", 32'(bad), 32'h0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("resume halted", 32'(halted), 32'h0);
    chk("resume t0_word", 32'(word), 32'(T0_WORD));
    chk("resume pc", 32'(pc), 32'h011);
    @(negedge clk);
    chk("resume T1 fetch", 32'({ir_ld, mem_rd, pc_inc, bus_sel}), 32'({3'b111, 3'd7}));

    // Reset asserted during T4 of ADD aborts it
    prep(16'h1020, 16'h0001, 16'h0100, 1'b0);
    repeat (4) @(negedge clk);
    chk("add T4 dr_ld", 32'(dr_ld), 32'h1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort strobes", 32'(word), 32'h0);
    chk("abort halted", 32'(halted), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("abort t0_word", 32'(word), 32'(T0_WORD));
    chk("abort ac kept", 32'(ac), 32'h0100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
